branch_predict_resolve: RTL and testbench

- Branch unit for the pipelined core; replaces the purely combinational PC-select decoder.
- Fetch stage: a parametrised branch history table (BHT) of saturating counters predicts the direction of conditional branches.
- Execute stage: resolves branches, jal and jalr from opcode, funct3 and ALU flags, then emits the PC-source select and a mispredict/flush pulse.
- Also trains the BHT and keeps saturating branch/mispredict statistics counters.

---
 rtl/core_pkg.sv | 48 ++++
 rtl/sat_counter_bank.sv | 48 ++++
 rtl/branch_predict_resolve.sv | 124 ++++++++++++
 tb/tb_branch_predict_resolve.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the branch unit.
// Holds the opcode-class and PC-source encodings, the funct3 values of the
// conditional branches, the ALU flag bit positions and the class decoder.
package core_pkg;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_BR   = 2'd1,
    CLS_JAL  = 2'd2,
    CLS_JALR = 2'd3
  } op_class_t;

  typedef enum logic [1:0] {
    PC_SEQ     = 2'b00,
    PC_TGT     = 2'b01,
    PC_JALR    = 2'b10,
    PC_RESTORE = 2'b11
  } pc_src_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int FLAG_EQ  = 1;
  localparam int FLAG_LT  = 2;
  localparam int FLAG_LTU = 3;

  // Only bit 6 and bits 3:2 of the opcode separate the control-flow classes.
  // funct3 010/011 are not branch encodings, so they fall back to NONE.
  function automatic op_class_t decode_class(input logic [6:0] op,
                                             input logic [2:0] f3);
    op_class_t cls;
    if (!op[6]) begin
      cls = CLS_NONE;
    end else begin
      case (op[3:2])
        2'b01:   cls = CLS_JALR;
        2'b11:   cls = CLS_JAL;
        default: cls = (f3[2:1] == 2'b01) ? CLS_NONE : CLS_BR;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/sat_counter_bank.sv
// Branch history table: an array of saturating up/down counters.
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset (loads INIT_CTR)
//   i_rd_idx         combinational read index
//   o_rd_ctr         counter value at i_rd_idx (pre-update, no bypass)
//   i_upd_en         apply an update this cycle
//   i_upd_inc        1 = increment toward max, 0 = decrement toward zero
//   i_upd_idx        index of the counter being updated
module sat_counter_bank #(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int INIT_CTR = 1,
  localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [IDX_W-1:0]    i_rd_idx,
  output logic [CTR_BITS-1:0] o_rd_ctr,
  input  logic                i_upd_en,
  input  logic                i_upd_inc,
  input  logic [IDX_W-1:0]    i_upd_idx
);

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(INIT_CTR);

  logic [CTR_BITS-1:0] r_ctr [ENTRIES];
  logic [CTR_BITS-1:0] w_upd_cur;

  assign o_rd_ctr  = r_ctr[i_rd_idx];
  assign w_upd_cur = r_ctr[i_upd_idx];

  // Reset wins over an update in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= CTR_INIT;
      end
    end else if (i_upd_en) begin
      if (i_upd_inc) begin
        if (w_upd_cur != CTR_MAX) r_ctr[i_upd_idx] <= w_upd_cur + CTR_BITS'(1);
      end else begin
        if (w_upd_cur != '0) r_ctr[i_upd_idx] <= w_upd_cur - CTR_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch unit: BHT direction prediction at fetch, branch/jal/jalr
// resolution at execute, BHT training and saturating statistics.
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   f_pc              fetch PC; f_pred_taken is its predicted direction
//   e_valid, e_op,
//   e_funct3, e_onzc  execute-stage instruction and ALU flags
//   e_pc              PC of the execute instruction (BHT training index)
//   e_pred_taken      prediction that travelled with the instruction
//   pc_src            PC-source select; mispredict = redirect/flush
//   branch_cnt        resolved conditional branches (saturating)
//   mispred_cnt       mispredicts of any kind (saturating)
module branch_predict_resolve
  import core_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int INIT_CTR    = 1,
  parameter int STAT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   f_pc,
  output logic              f_pred_taken,
  input  logic              e_valid,
  input  logic [6:0]        e_op,
  input  logic [2:0]        e_funct3,
  input  logic [3:0]        e_onzc,
  input  logic [XLEN-1:0]   e_pc,
  input  logic              e_pred_taken,
  output logic [1:0]        pc_src,
  output logic              mispredict,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

  logic [IDX_W-1:0]    w_f_idx;
  logic [IDX_W-1:0]    w_e_idx;
  logic [CTR_BITS-1:0] w_f_ctr;
  op_class_t           w_cls;
  logic                w_taken;
  pc_src_t             w_pc_src;
  logic                w_br_valid;
  logic [STAT_W-1:0]   r_branch_cnt;
  logic [STAT_W-1:0]   r_mispred_cnt;
  logic                w_unused_bits;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  assign w_f_idx = f_pc[IDX_W+1:2];
  assign w_e_idx = e_pc[IDX_W+1:2];

  sat_counter_bank #(
    .ENTRIES  (BHT_ENTRIES),
    .CTR_BITS (CTR_BITS),
    .INIT_CTR (INIT_CTR)
  ) u_bht (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_rd_idx  (w_f_idx),
    .o_rd_ctr  (w_f_ctr),
    .i_upd_en  (w_br_valid),
    .i_upd_inc (w_taken),
    .i_upd_idx (w_e_idx)
  );

  assign f_pred_taken = !reset && w_f_ctr[CTR_BITS-1];

  // Execute-stage resolution, all combinational.
  always_comb begin
    w_cls   = decode_class(e_op, e_funct3);
    w_taken = 1'b0;
    case (e_funct3)
      F3_BEQ:  w_taken =  e_onzc[FLAG_EQ];
      F3_BNE:  w_taken = !e_onzc[FLAG_EQ];
      F3_BLT:  w_taken =  e_onzc[FLAG_LT];
      F3_BGE:  w_taken = !e_onzc[FLAG_LT];
      F3_BLTU: w_taken =  e_onzc[FLAG_LTU];
      F3_BGEU: w_taken = !e_onzc[FLAG_LTU];
      default: w_taken = 1'b0;
    endcase

    w_pc_src = PC_SEQ;
    if (e_valid && !reset) begin
      case (w_cls)
        CLS_JALR: w_pc_src = PC_JALR;
        CLS_JAL:  if (!e_pred_taken) w_pc_src = PC_TGT;
        CLS_BR: begin
          if (w_taken && !e_pred_taken)      w_pc_src = PC_TGT;
          else if (!w_taken && e_pred_taken) w_pc_src = PC_RESTORE;
        end
        default: w_pc_src = PC_SEQ;
      endcase
    end
  end

  assign pc_src     = w_pc_src;
  assign mispredict = (w_pc_src != PC_SEQ);
  assign w_br_valid = e_valid && (w_cls == CLS_BR);

  // Statistics, updated on the clock edge that retires the execute slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_br_valid) r_branch_cnt  <= sat_inc(r_branch_cnt);
      if (mispredict) r_mispred_cnt <= sat_inc(r_mispred_cnt);
    end
  end

  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

  assign w_unused_bits = ^{f_pc[XLEN-1:IDX_W+2], f_pc[1:0],
                           e_pc[XLEN-1:IDX_W+2], e_pc[1:0],
                           e_onzc[0], e_op[5:4], e_op[1:0]};

endmodule

// File: tb/tb_branch_predict_resolve.sv
module tb_branch_predict_resolve;

  localparam int STAT_W = 4;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       f_pc;
  logic              f_pred_taken;
  logic              e_valid;
  logic [6:0]        e_op;
  logic [2:0]        e_funct3;
  logic [3:0]        e_onzc;
  logic [31:0]       e_pc;
  logic              e_pred_taken;
  logic [1:0]        pc_src;
  logic              mispredict;
  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] mispred_cnt;

  int checks = 0;
  int errors = 0;
  int exp_br = 0;
  int exp_mp = 0;

  typedef struct {
    logic [2:0] f3;
    logic [3:0] onzc;
    bit         is_br;
    bit         taken;
  } vec_t;

  vec_t tbl [13];

  always #5 clk = ~clk;

  branch_predict_resolve #(
    .XLEN(32), .BHT_ENTRIES(64), .CTR_BITS(2), .INIT_CTR(1), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .e_valid(e_valid), .e_op(e_op), .e_funct3(e_funct3), .e_onzc(e_onzc),
    .e_pc(e_pc), .e_pred_taken(e_pred_taken), .pc_src(pc_src),
    .mispredict(mispredict), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; bench-side model of the saturating statistics.
  task automatic adv(input bit br, input bit mp);
    @(posedge clk);
    #1;
    if (br && exp_br < 15) exp_br++;
    if (mp && exp_mp < 15) exp_mp++;
  endtask

  task automatic set_br(input logic [2:0] f3, input logic [3:0] onzc,
                        input logic [31:0] pc, input logic pred);
    e_valid = 1'b1; e_op = OP_BR; e_funct3 = f3; e_onzc = onzc;
    e_pc = pc; e_pred_taken = pred;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_br"}, 32'(branch_cnt), 32'(exp_br));
    chk({tag, "_mp"}, 32'(mispred_cnt), 32'(exp_mp));
  endtask

  initial begin
    tbl[0]  = '{3'b001, 4'b0000, 1'b1, 1'b1};
    tbl[1]  = '{3'b001, 4'b0010, 1'b1, 1'b0};
    tbl[2]  = '{3'b100, 4'b0100, 1'b1, 1'b1};
    tbl[3]  = '{3'b100, 4'b0000, 1'b1, 1'b0};
    tbl[4]  = '{3'b101, 4'b0000, 1'b1, 1'b1};
    tbl[5]  = '{3'b101, 4'b0100, 1'b1, 1'b0};
    tbl[6]  = '{3'b110, 4'b1000, 1'b1, 1'b1};
    tbl[7]  = '{3'b110, 4'b0000, 1'b1, 1'b0};
    tbl[8]  = '{3'b111, 4'b0000, 1'b1, 1'b1};
    tbl[9]  = '{3'b111, 4'b1000, 1'b1, 1'b0};
    tbl[10] = '{3'b010, 4'b1111, 1'b0, 1'b0};
    tbl[11] = '{3'b011, 4'b0000, 1'b0, 1'b0};
    tbl[12] = '{3'b000, 4'b1101, 1'b1, 1'b0};

    reset = 1'b1; f_pc = 32'h100;
    e_valid = 1'b0; e_op = '0; e_funct3 = '0; e_onzc = '0; e_pc = '0; e_pred_taken = 1'b0;
    @(posedge clk); #1;
    // Reset held with a mispredicting branch presented: outputs stay quiet.
    set_br(3'b000, 4'b0010, 32'h100, 1'b0);
    #1;
    chk("rst_pc_src", 32'(pc_src), 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_pred", 32'(f_pred_taken), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; e_valid = 1'b0;
    #1;
    chk_cnt("rst_cnt");
    f_pc = 32'h0;  #1; chk("rst_pred_0", 32'(f_pred_taken), 32'd0);
    f_pc = 32'hFC; #1; chk("rst_pred_fc", 32'(f_pred_taken), 32'd0);
    f_pc = 32'h100; #1; chk("rst_pred_100", 32'(f_pred_taken), 32'd0);

    // beq taken, predicted not-taken.
    set_br(3'b000, 4'b0010, 32'h100, 1'b0); #1;
    chk("beq_pc_src", 32'(pc_src), 32'd1);
    chk("beq_mispredict", 32'(mispredict), 32'd1);
    adv(1, 1);
    e_valid = 1'b0; #1;
    chk("beq_trained", 32'(f_pred_taken), 32'd1);
    chk_cnt("beq_cnt");

    // Three more taken (predicted taken), then a not-taken restore.
    for (int i = 0; i < 3; i++) begin
      set_br(3'b000, 4'b0010, 32'h100, 1'b1); #1;
      chk("taken_hit_pc_src", 32'(pc_src), 32'd0);
      adv(1, 0);
    end
    set_br(3'b000, 4'b0000, 32'h100, 1'b1); #1;
    chk("restore_pc_src", 32'(pc_src), 32'd3);
    chk("restore_mispredict", 32'(mispredict), 32'd1);
    adv(1, 1);
    e_valid = 1'b0; #1;
    chk("ctr3to2_pred", 32'(f_pred_taken), 32'd1);
    set_br(3'b000, 4'b0000, 32'h100, 1'b1);
    adv(1, 1);
    e_valid = 1'b0; #1;
    chk("ctr2to1_pred", 32'(f_pred_taken), 32'd0);
    chk_cnt("restore_cnt");

    // JALR / JAL: no BHT change, no branch count.
    e_valid = 1'b1; e_op = OP_JALR; e_pc = 32'h100; e_pred_taken = 1'b0; #1;
    chk("jalr_pc_src", 32'(pc_src), 32'd2);
    chk("jalr_mispredict", 32'(mispredict), 32'd1);
    adv(0, 1);
    e_op = OP_JAL; e_pred_taken = 1'b1; #1;
    chk("jal_hit_pc_src", 32'(pc_src), 32'd0);
    chk("jal_hit_mispredict", 32'(mispredict), 32'd0);
    adv(0, 0);
    e_pred_taken = 1'b0; #1;
    chk("jal_miss_pc_src", 32'(pc_src), 32'd1);
    adv(0, 1);
    e_op = OP_ALU; #1;
    chk("none_pc_src", 32'(pc_src), 32'd0);
    adv(0, 0);
    set_br(3'b000, 4'b0010, 32'h100, 1'b0); e_valid = 1'b0; #1;
    chk("invalid_pc_src", 32'(pc_src), 32'd0);
    adv(0, 0);
    #1;
    chk("jump_bht_untouched", 32'(f_pred_taken), 32'd0);
    chk_cnt("jump_cnt");

    // Same-cycle read/write on one index: old value now, new value next cycle.
    f_pc = 32'h40;
    set_br(3'b000, 4'b0010, 32'h40, 1'b0); #1;
    chk("rw_same_cycle", 32'(f_pred_taken), 32'd0);
    adv(1, 1);
    e_valid = 1'b0; #1;
    chk("rw_next_cycle", 32'(f_pred_taken), 32'd1);

    // Saturation at zero: 1 -> 0 -> 0 -> 1 keeps prediction not-taken.
    f_pc = 32'h300;
    set_br(3'b000, 4'b0000, 32'h300, 1'b0); #1;
    chk("nt_hit_pc_src", 32'(pc_src), 32'd0);
    adv(1, 0);
    set_br(3'b000, 4'b0000, 32'h300, 1'b0); adv(1, 0);
    set_br(3'b000, 4'b0010, 32'h300, 1'b0); adv(1, 1);
    e_valid = 1'b0; #1;
    chk("sat_zero_pred", 32'(f_pred_taken), 32'd0);

    // funct3 conditions, predicted not-taken.
    for (int i = 0; i < 13; i++) begin
      set_br(tbl[i].f3, tbl[i].onzc, 32'h600, 1'b0); #1;
      chk($sformatf("f3_%0d_pc_src", i), 32'(pc_src), tbl[i].taken ? 32'd1 : 32'd0);
      adv(tbl[i].is_br, tbl[i].taken);
    end
    e_valid = 1'b0; #1;
    chk_cnt("table_cnt");

    // Reset with a simultaneous update at idx(0x40) (counter currently 2).
    reset = 1'b1;
    set_br(3'b000, 4'b0010, 32'h40, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; e_valid = 1'b0; f_pc = 32'h40;
    exp_br = 0; exp_mp = 0;
    #1;
    chk_cnt("rst2_cnt");
    chk("rst2_pred", 32'(f_pred_taken), 32'd0);
    set_br(3'b000, 4'b0010, 32'h40, 1'b1); adv(1, 0);
    e_valid = 1'b0; #1;
    chk("rst2_entry_init", 32'(f_pred_taken), 32'd1);

    // Statistics saturation with 20 mispredicting branches.
    for (int i = 0; i < 20; i++) begin
      set_br(3'b000, 4'b0010, 32'h500, 1'b0);
      adv(1, 1);
      if (i == 13) chk_cnt("sat_mid");
    end
    e_valid = 1'b0; #1;
    chk_cnt("sat_end");
    chk("sat_br_15", 32'(branch_cnt), 32'd15);
    chk("sat_mp_15", 32'(mispred_cnt), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
